// File: rtl/alu_dispatch.sv
// alu_dispatch: RV32I ALU issue stage (IDLE -> EXEC -> RESP) with decode, operand registers and result capture.
// Optional feature: define ALU_DISPATCH_BACK2BACK_EN to accept a new instruction in the same cycle a result is taken.
module alu_dispatch #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_dat,
  input  logic [31:0] rs2_dat,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [2:0]  ALU_opcode,
  output logic        ALU_opcode_differentiator,
  output logic        ALU_optype,
  output logic        dat_ready,
  input  logic [31:0] ALU_out,
  input  logic        ALU_branch,
  input  logic        ALU_zero,
  input  logic        ALU_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_branch,
  output logic        res_zero,
  output logic        res_overflow,
  output logic        res_illegal
);
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dat1_q, dat1_d, dat2_q, dat2_d;
  logic [2:0]  opcode_q, opcode_d;
  logic        diff_q, diff_d, optype_q, optype_d;
  logic        dat_ready_q, dat_ready_d, res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_branch_q, res_branch_d, res_zero_q, res_zero_d;
  logic        res_overflow_q, res_overflow_d, res_illegal_q, res_illegal_d;

  logic        dec_legal, dec_optype, dec_diff, shift_imm, accept;
  logic [31:0] dec_dat2;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^{instr[19:15], instr[11:7]};
  // funct3 001/101 are the shift-immediate forms: only imm[4:0] is the shift amount.
  assign shift_imm = (instr[13:12] == 2'b01);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    dec_legal  = 1'b1;
    dec_optype = 1'b0;
    dec_diff   = 1'b0;
    dec_dat2   = rs2_dat;
    case (instr[6:0])
      OPC_R: dec_diff = instr[30];
      OPC_I: begin
        dec_diff = (instr[14:12] == 3'b101) & instr[30];
        dec_dat2 = shift_imm ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
      end
      OPC_B:   dec_optype = 1'b1;
      default: dec_legal  = 1'b0;
    endcase
  end

`ifdef ALU_DISPATCH_BACK2BACK_EN
  assign issue_ready = (state_q == IDLE) || ((state_q == RESP) && res_ready);
`else
  assign issue_ready = (state_q == IDLE);
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dat1_d         = dat1_q;
    dat2_d         = dat2_q;
    opcode_d       = opcode_q;
    diff_d         = diff_q;
    optype_d       = optype_q;
    res_data_d     = res_data_q;
    res_branch_d   = res_branch_q;
    res_zero_d     = res_zero_q;
    res_overflow_d = res_overflow_q;
    res_illegal_d  = res_illegal_q;
    accept         = issue_valid && issue_ready;

    case (state_q)
      IDLE: ;
      EXEC: begin
        if (cnt_q == CNT_LAST) begin
          state_d        = RESP;
          cnt_d          = '0;
          res_data_d     = optype_q ? 32'd0 : ALU_out;
          res_branch_d   = optype_q & ALU_branch;
          res_zero_d     = ALU_zero;
          res_overflow_d = ALU_overflow;
          res_illegal_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A transfer from IDLE, or from RESP when back-to-back issue is on, overrides the above.
    if (accept) begin
      dat1_d   = rs1_dat;
      dat2_d   = dec_dat2;
      opcode_d = instr[14:12];
      diff_d   = dec_diff;
      optype_d = dec_optype;
      cnt_d    = '0;
      if (dec_legal) begin
        state_d = EXEC;
      end else begin
        state_d        = RESP;
        res_data_d     = '0;
        res_branch_d   = 1'b0;
        res_zero_d     = 1'b0;
        res_overflow_d = 1'b0;
        res_illegal_d  = 1'b1;
      end
    end

    dat_ready_d = (state_d == EXEC);
    res_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample the same pre-edge values.
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dat1_q         <= '0;
      dat2_q         <= '0;
      opcode_q       <= '0;
      diff_q         <= 1'b0;
      optype_q       <= 1'b0;
      dat_ready_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_branch_q   <= 1'b0;
      res_zero_q     <= 1'b0;
      res_overflow_q <= 1'b0;
      res_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dat1_q         <= dat1_d;
      dat2_q         <= dat2_d;
      opcode_q       <= opcode_d;
      diff_q         <= diff_d;
      optype_q       <= optype_d;
      dat_ready_q    <= dat_ready_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_branch_q   <= res_branch_d;
      res_zero_q     <= res_zero_d;
      res_overflow_q <= res_overflow_d;
      res_illegal_q  <= res_illegal_d;
    end
  end

  assign ALU_dat1                  = dat1_q;
  assign ALU_dat2                  = dat2_q;
  assign ALU_opcode                = opcode_q;
  assign ALU_opcode_differentiator = diff_q;
  assign ALU_optype                = optype_q;
  assign dat_ready                 = dat_ready_q;
  assign res_valid                 = res_valid_q;
  assign res_data                  = res_data_q;
  assign res_branch                = res_branch_q;
  assign res_zero                  = res_zero_q;
  assign res_overflow              = res_overflow_q;
  assign res_illegal               = res_illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed RV32I cases, randomized traffic against a decode/timing model,
// backpressure, back-to-back issue (ALU_DISPATCH_BACK2BACK_EN) and reset during execution.
`timescale 1ns/1ps
module tb_alu_dispatch;
  localparam int LAT = 3;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [31:0] instr, rs1_dat, rs2_dat;
  logic [31:0] ALU_dat1, ALU_dat2;
  logic [2:0]  ALU_opcode;
  logic        ALU_opcode_differentiator, ALU_optype, dat_ready;
  logic [31:0] ALU_out;
  logic        ALU_branch, ALU_zero, ALU_overflow;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_branch, res_zero, res_overflow, res_illegal;

  int n_pass  = 0;
  int n_total = 0;

  // Expectations of the transaction currently sitting in RESP.
  logic [35:0] exp_res;
  logic [68:0] exp_ops;
  logic        exp_ops_valid;

  alu_dispatch #(.LATENCY(LAT)) dut (
    .soc_clk                   (soc_clk),
    .reset                     (reset),
    .issue_valid               (issue_valid),
    .issue_ready               (issue_ready),
    .instr                     (instr),
    .rs1_dat                   (rs1_dat),
    .rs2_dat                   (rs2_dat),
    .ALU_dat1                  (ALU_dat1),
    .ALU_dat2                  (ALU_dat2),
    .ALU_opcode                (ALU_opcode),
    .ALU_opcode_differentiator (ALU_opcode_differentiator),
    .ALU_optype                (ALU_optype),
    .dat_ready                 (dat_ready),
    .ALU_out                   (ALU_out),
    .ALU_branch                (ALU_branch),
    .ALU_zero                  (ALU_zero),
    .ALU_overflow              (ALU_overflow),
    .res_valid                 (res_valid),
    .res_ready                 (res_ready),
    .res_data                  (res_data),
    .res_branch                (res_branch),
    .res_zero                  (res_zero),
    .res_overflow              (res_overflow),
    .res_illegal               (res_illegal)
  );

  always #5 soc_clk = ~soc_clk;

  // Reference decode written straight from the instruction-set rules.
  function automatic void model_decode(input logic [31:0] ins, input logic [31:0] rs2,
                                       output logic legal, output logic is_b,
                                       output logic diff, output logic [31:0] dat2);
    int unsigned opc, f3;
    int imm;
    opc   = ins[6:0];
    f3    = ins[14:12];
    legal = (opc == 'h33) || (opc == 'h13) || (opc == 'h63);
    is_b  = (opc == 'h63);
    diff  = 1'b0;
    dat2  = rs2;
    if (opc == 'h33) diff = ins[30];
    if (opc == 'h13) begin
      if (f3 == 5) diff = ins[30];
      if (f3 == 1 || f3 == 5) begin
        dat2 = ins[24:20];
      end else begin
        imm = ins[31:20];
        if (imm >= 2048) imm = imm - 4096;
        dat2 = imm;
      end
    end
  endfunction

  task automatic drive_alu_garbage();
    ALU_out      = $urandom;
    ALU_branch   = 1'($urandom);
    ALU_zero     = 1'($urandom);
    ALU_overflow = 1'($urandom);
  endtask

  // Issues one instruction (unless the caller already transferred it) and follows it cycle by cycle up to res_valid.
  task automatic issue_and_wait(input string name, input logic [31:0] ins, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] aluv, input logic br,
                                input logic z, input logic ov, input bit pre_accepted);
    logic legal, is_b, diff;
    logic [31:0] dat2;
    int last;
    model_decode(ins, rs2, legal, is_b, diff, dat2);
    exp_ops       = {rs1, dat2, ins[14:12], diff, is_b};
    exp_ops_valid = legal;
    exp_res       = {(legal && !is_b) ? aluv : 32'd0, legal && is_b && br, legal && z, legal && ov, !legal};
    if (!pre_accepted) begin
      issue_valid = 1'b1;
      instr       = ins;
      rs1_dat     = rs1;
      rs2_dat     = rs2;
      #1;
      n_total++;
      if (issue_ready !== 1'b1) $display("FAIL %s issue_ready_idle: got %b want 1", name, issue_ready);
      else n_pass++;
      @(posedge soc_clk);
      #1;
      issue_valid = 1'b0;
      instr       = $urandom;
      rs1_dat     = $urandom;
      rs2_dat     = $urandom;
    end
    last = legal ? LAT + 1 : 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge soc_clk);
      n_total++;
      if (dat_ready !== (legal && (k <= LAT)))
        $display("FAIL %s dat_ready cycle %0d: got %b want %b", name, k, dat_ready, legal && (k <= LAT));
      else n_pass++;
      n_total++;
      if (res_valid !== (k == last))
        $display("FAIL %s res_valid cycle %0d: got %b want %b", name, k, res_valid, k == last);
      else n_pass++;
      if (legal && k <= LAT) begin
        n_total++;
        if ({ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype} !== exp_ops)
          $display("FAIL %s alu_operands cycle %0d: got %h want %h", name, k,
                   {ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype}, exp_ops);
        else n_pass++;
      end
      // Real ALU results are presented only during the final dat_ready cycle.
      if (legal && k == LAT) begin
        ALU_out      = aluv;
        ALU_branch   = br;
        ALU_zero     = z;
        ALU_overflow = ov;
      end else begin
        drive_alu_garbage();
      end
    end
    n_total++;
    if ({res_data, res_branch, res_zero, res_overflow, res_illegal} !== exp_res)
      $display("FAIL %s result: got %h want %h", name,
               {res_data, res_branch, res_zero, res_overflow, res_illegal}, exp_res);
    else n_pass++;
  endtask

  task automatic hold_resp(input string name, input int cycles);
    for (int h = 0; h < cycles; h++) begin
      issue_valid = 1'b1;
      instr       = $urandom;
      rs1_dat     = $urandom;
      rs2_dat     = $urandom;
      drive_alu_garbage();
      @(negedge soc_clk);
      n_total++;
      if ({res_valid, dat_ready, issue_ready} !== 3'b100)
        $display("FAIL %s hold_ctrl %0d: got %b want 100", name, h, {res_valid, dat_ready, issue_ready});
      else n_pass++;
      n_total++;
      if ({res_data, res_branch, res_zero, res_overflow, res_illegal} !== exp_res)
        $display("FAIL %s hold_result %0d: got %h want %h", name, h,
                 {res_data, res_branch, res_zero, res_overflow, res_illegal}, exp_res);
      else n_pass++;
      if (exp_ops_valid) begin
        n_total++;
        if ({ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype} !== exp_ops)
          $display("FAIL %s hold_operands %0d: got %h want %h", name, h,
                   {ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype}, exp_ops);
        else n_pass++;
      end
    end
    issue_valid = 1'b0;
  endtask

  task automatic release_resp(input string name);
    logic exp_ir;
`ifdef ALU_DISPATCH_BACK2BACK_EN
    exp_ir = 1'b1;
`else
    exp_ir = 1'b0;
`endif
    res_ready   = 1'b1;
    issue_valid = 1'b0;
    #1;
    n_total++;
    if (issue_ready !== exp_ir) $display("FAIL %s issue_ready_release: got %b want %b", name, issue_ready, exp_ir);
    else n_pass++;
    @(posedge soc_clk);
    #1;
    res_ready = 1'b0;
    @(negedge soc_clk);
    n_total++;
    if ({res_valid, dat_ready, issue_ready} !== 3'b001)
      $display("FAIL %s after_release: got %b want 001", name, {res_valid, dat_ready, issue_ready});
    else n_pass++;
  endtask

  task automatic run_op(input string name, input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] aluv, input logic br,
                        input logic z, input logic ov, input int hold);
    issue_and_wait(name, ins, rs1, rs2, aluv, br, z, ov, 1'b0);
    hold_resp(name, hold);
    release_resp(name);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    issue_valid = 1'b0;
    res_ready   = 1'b0;
    instr       = '0;
    rs1_dat     = '0;
    rs2_dat     = '0;
    ALU_out     = '0;
    ALU_branch  = 1'b0;
    ALU_zero    = 1'b0;
    ALU_overflow = 1'b0;
    repeat (3) @(posedge soc_clk);
    #1;
    reset = 1'b0;
    @(negedge soc_clk);
    n_total++;
    if ({dat_ready, res_valid, issue_ready} !== 3'b001)
      $display("FAIL reset_ctrl: got %b want 001", {dat_ready, res_valid, issue_ready});
    else n_pass++;
    n_total++;
    if ({ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype} !== 69'd0)
      $display("FAIL reset_operands: got %h want 0", {ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype});
    else n_pass++;
    n_total++;
    if ({res_data, res_branch, res_zero, res_overflow, res_illegal} !== 36'd0)
      $display("FAIL reset_result: got %h want 0", {res_data, res_branch, res_zero, res_overflow, res_illegal});
    else n_pass++;
  endtask

  task automatic test_directed();
    run_op("r_add",     32'h002081B3, 32'd5,        32'd7,        32'd12,        1'b0, 1'b0, 1'b0, 0);
    run_op("r_sub",     32'h402081B3, 32'd9,        32'd4,        32'd5,         1'b0, 1'b0, 1'b1, 1);
    run_op("i_srai",    32'h4030D093, 32'hF0000000, 32'h55555555, 32'hFE000000,  1'b0, 1'b0, 1'b0, 0);
    run_op("i_addi_m1", 32'hFFF08093, 32'd1,        32'h12345678, 32'd0,         1'b0, 1'b1, 1'b0, 0);
    run_op("i_slli",    32'h00509093, 32'd3,        32'hAAAAAAAA, 32'd96,        1'b0, 1'b0, 1'b0, 0);
    run_op("i_slti",    32'h40002093, 32'd7,        32'hFFFFFFFF, 32'd1,         1'b0, 1'b0, 1'b0, 0);
    run_op("b_beq",     32'h00208463, 32'd8,        32'd8,        32'hDEADBEEF,  1'b1, 1'b1, 1'b0, 0);
    run_op("illegal",   32'h00000037, 32'd1,        32'd2,        32'hCAFEF00D,  1'b1, 1'b1, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 32'h002081B3, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b0, 5);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 3))
        0: ins[6:0] = 7'h33;
        1: ins[6:0] = 7'h13;
        2: ins[6:0] = 7'h63;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), ins, $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    issue_and_wait("b2b_first", 32'h002081B3, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    res_ready   = 1'b1;
    issue_valid = 1'b1;
    instr       = 32'hFFF08093;
    rs1_dat     = 32'h1234;
    rs2_dat     = 32'h9999;
    #1;
`ifdef ALU_DISPATCH_BACK2BACK_EN
    n_total++;
    if (issue_ready !== 1'b1) $display("FAIL b2b_issue_ready: got %b want 1", issue_ready);
    else n_pass++;
    @(posedge soc_clk);
    #1;
    res_ready   = 1'b0;
    issue_valid = 1'b0;
    instr       = $urandom;
    issue_and_wait("b2b_second", 32'hFFF08093, 32'h1234, 32'h9999, 32'd77, 1'b0, 1'b0, 1'b0, 1'b1);
    // An illegal instruction taken back-to-back stays in RESP with a fresh illegal result.
    res_ready   = 1'b1;
    issue_valid = 1'b1;
    instr       = 32'h00000037;
    @(posedge soc_clk);
    #1;
    res_ready   = 1'b0;
    issue_valid = 1'b0;
    instr       = $urandom;
    issue_and_wait("b2b_illegal", 32'h00000037, 32'h1234, 32'h9999, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    release_resp("b2b_illegal");
`else
    n_total++;
    if (issue_ready !== 1'b0) $display("FAIL b2b_issue_ready: got %b want 0", issue_ready);
    else n_pass++;
    @(posedge soc_clk);
    #1;
    res_ready   = 1'b0;
    issue_valid = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge soc_clk);
      n_total++;
      if ({res_valid, dat_ready, issue_ready} !== 3'b001)
        $display("FAIL b2b_dropped cycle %0d: got %b want 001", k, {res_valid, dat_ready, issue_ready});
      else n_pass++;
    end
`endif
  endtask

  task automatic test_reset_mid_exec();
    issue_valid = 1'b1;
    instr       = 32'h002081B3;
    rs1_dat     = 32'd5;
    rs2_dat     = 32'd7;
    @(posedge soc_clk);
    #1;
    issue_valid = 1'b0;
    @(negedge soc_clk);
    n_total++;
    if (dat_ready !== 1'b1) $display("FAIL rst_exec_dat_ready: got %b want 1", dat_ready);
    else n_pass++;
    @(posedge soc_clk);
    #1;
    reset = 1'b1;
    #1;
    n_total++;
    if ({dat_ready, res_valid, ALU_dat1, ALU_dat2, res_data} !== 98'd0)
      $display("FAIL rst_exec_outputs: got %h want 0", {dat_ready, res_valid, ALU_dat1, ALU_dat2, res_data});
    else n_pass++;
    @(posedge soc_clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      @(negedge soc_clk);
      n_total++;
      if ({res_valid, dat_ready} !== 2'b00)
        $display("FAIL rst_exec_no_resp cycle %0d: got %b want 00", k, {res_valid, dat_ready});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
